// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: pipeline stage register with a 2-entry skid buffer, valid/ready handshake, flush and halt.
// Optional statistics counters are enabled by defining PIPE_STAGE_STATS_EN. Revision 1.0.
`default_nettype none

module pipe_stage_skid_reg #(
  parameter int DATA_W     = 128,
  parameter int CLEAR_DATA = 1,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hlt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              m_v;
  logic              s_v;
  logic              acc;
  logic              take;
  logic [DATA_W-1:0] m_d;
  logic [DATA_W-1:0] s_d;

  if (DATA_W < 1 || STAT_W < 1) begin : g_param_check
    $error("pipe_stage_skid_reg: DATA_W and STAT_W must be positive");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (acc) state_nxt = ONE;
        ONE: begin
          if (acc && !take)      state_nxt = FULL;
          else if (!acc && take) state_nxt = EMPTY;
        end
        FULL:    if (take) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // in_ready depends only on registered state and hlt, never on out_ready
  always_comb begin
    m_v       = (state != EMPTY);
    s_v       = (state == FULL);
    in_ready  = ~s_v & ~hlt;
    out_valid = m_v & ~hlt;
  end

  assign acc      = in_valid & in_ready & ~flush;
  assign take     = out_valid & out_ready;
  assign out_data = m_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_d <= '0;
      s_d <= '0;
    end else if (flush) begin
      if (CLEAR_DATA != 0) begin
        m_d <= '0;
        s_d <= '0;
      end
    end else begin
      case (state)
        EMPTY: if (acc) m_d <= in_data;
        ONE: begin
          if (acc && take)  m_d <= in_data;
          if (acc && !take) s_d <= in_data;
        end
        FULL:    if (take) m_d <= s_d;
        default: ;
      endcase
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

  // Saturating counters; clear takes precedence over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + STAT_ONE;
      if (!m_v && !hlt && bubble_cnt != '1)           bubble_cnt <= bubble_cnt + STAT_ONE;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed scenarios plus randomized traffic against a queue-based model.
`timescale 1ns/1ps
`default_nettype none

module tb_pipe_stage_skid_reg;

  localparam int DW = 32;
  localparam int SW = 3;
  localparam int STAT_MAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          hlt = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          stat_clr = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
  logic [SW-1:0] stall_cnt;
  logic [SW-1:0] bubble_cnt;
`endif

  pipe_stage_skid_reg #(.DATA_W(DW), .CLEAR_DATA(1), .STAT_W(SW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .hlt       (hlt),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: FIFO of accepted-but-undelivered beats (at most two) and the last value left on out_data
  logic [DW-1:0] mq[$];
  logic [DW-1:0] shadow = '0;
  logic          exp_ir;
  logic          exp_ov;
  logic [DW-1:0] exp_od;
  int            exp_stall = 0;
  int            exp_bub = 0;

  task automatic set_in(input logic h, input logic f, input logic iv, input logic [DW-1:0] d,
                        input logic r, input logic clr = 1'b0);
    @(negedge clk);
    rst_n = 1'b1; hlt = h; flush = f; in_valid = iv; in_data = d; out_ready = r; stat_clr = clr;
    #1;
    exp_ir = (mq.size() < 2) && !h;
    exp_ov = (mq.size() > 0) && !h;
    exp_od = (mq.size() > 0) ? mq[0] : shadow;
  endtask

  task automatic adv();
    logic acc, take;
    acc  = in_valid && exp_ir && !flush;
    take = exp_ov && out_ready;
    if (stat_clr) begin
      exp_stall = 0; exp_bub = 0;
    end else begin
      if (exp_ov && !out_ready && exp_stall < STAT_MAX) exp_stall++;
      if (mq.size() == 0 && !hlt && exp_bub < STAT_MAX) exp_bub++;
    end
    if (take) shadow = mq.pop_front();
    if (flush) begin
      mq.delete();
      shadow = '0;
    end else if (acc) begin
      mq.push_back(in_data);
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; hlt = 1'b0; flush = 1'b0; in_valid = 1'b0; stat_clr = 1'b0;
    #1;
    mq.delete();
    shadow = '0; exp_stall = 0; exp_bub = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 3;
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0)    begin failures++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
  endtask

  task automatic test_stream();
    for (int k = 0; k <= 8; k++) begin
      set_in(1'b0, 1'b0, k < 8, DW'(k + 1), 1'b1);
      checks += 2;
      if (out_valid !== (k >= 1)) begin failures++; $display("FAIL stream_valid k=%0d got=%b", k, out_valid); end
      if (in_ready !== 1'b1)      begin failures++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
      if (k >= 1) begin
        checks++;
        if (out_data !== DW'(k)) begin failures++; $display("FAIL stream_data got=%h exp=%h", out_data, k); end
      end
      adv();
    end
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", out_valid); end
    adv();
  endtask

  task automatic test_skid();
    set_in(1'b0, 1'b0, 1'b1, 'hA, 1'b0); adv();
    set_in(1'b0, 1'b0, 1'b1, 'hB, 1'b0);
    checks += 2;
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL skid_ready_one got=%b exp=1", in_ready); end
    if (out_data !== 'hA)   begin failures++; $display("FAIL skid_head got=%h exp=a", out_data); end
    adv();
    set_in(1'b0, 1'b0, 1'b1, 'hD, 1'b0);
    checks += 2;
    if (in_ready !== 1'b0)  begin failures++; $display("FAIL skid_full_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL skid_full_valid got=%b exp=1", out_valid); end
    adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_data !== 'hA)   begin failures++; $display("FAIL skid_first got=%h exp=a", out_data); end
    adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks += 2;
    if (out_valid !== 1'b1 || out_data !== 'hB) begin
      failures++; $display("FAIL skid_second got=%b/%h exp=1/b", out_valid, out_data);
    end
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL skid_ready_after got=%b exp=1", in_ready); end
    adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_empty got=%b exp=0", out_valid); end
    adv();
  endtask

  task automatic test_flush();
    set_in(1'b0, 1'b0, 1'b1, 'hA, 1'b0); adv();
    set_in(1'b0, 1'b0, 1'b1, 'hB, 1'b0); adv();
    set_in(1'b0, 1'b1, 1'b1, 'hC, 1'b0); adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    if (out_data !== '0)    begin failures++; $display("FAIL flush_data got=%h exp=0", out_data); end
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL flush_ready got=%b exp=1", in_ready); end
    adv();
    set_in(1'b0, 1'b1, 1'b1, 'hE, 1'b1); adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_offer got=%b exp=0", out_valid); end
    adv();
  endtask

  task automatic test_halt();
    set_in(1'b0, 1'b0, 1'b1, 'h5, 1'b0); adv();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b0, 1'b1, 'h9, 1'b1);
      checks += 3;
      if (out_valid !== 1'b0) begin failures++; $display("FAIL halt_valid got=%b exp=0", out_valid); end
      if (in_ready !== 1'b0)  begin failures++; $display("FAIL halt_ready got=%b exp=0", in_ready); end
      if (out_data !== 'h5)   begin failures++; $display("FAIL halt_data got=%h exp=5", out_data); end
      adv();
    end
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 'h5) begin
      failures++; $display("FAIL halt_release got=%b/%h exp=1/5", out_valid, out_data);
    end
    adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL halt_once got=%b exp=0", out_valid); end
    adv();
  endtask

  task automatic test_reset_mid();
    set_in(1'b0, 1'b0, 1'b1, 'hA, 1'b0); adv();
    set_in(1'b0, 1'b0, 1'b1, 'hB, 1'b0); adv();
    #2;
    do_reset();
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    if (in_ready !== 1'b1)  begin failures++; $display("FAIL rstmid_ready got=%b exp=1", in_ready); end
    if (out_data !== '0)    begin failures++; $display("FAIL rstmid_data got=%h exp=0", out_data); end
    set_in(1'b0, 1'b0, 1'b1, 'h7, 1'b1); adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 'h7) begin
      failures++; $display("FAIL rstmid_beat got=%b/%h exp=1/7", out_valid, out_data);
    end
    adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_alone got=%b exp=0", out_valid); end
    adv();
  endtask

`ifdef PIPE_STAGE_STATS_EN
  task automatic test_stats();
    do_reset();
    set_in(1'b0, 1'b0, 1'b1, 'h3, 1'b0); adv();
    for (int k = 0; k < 4; k++) begin set_in(1'b0, 1'b0, 1'b0, '0, 1'b0); adv(); end
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
    checks++;
    if (stall_cnt !== 3'd4) begin failures++; $display("FAIL stats_stall4 got=%0d exp=4", stall_cnt); end
    adv();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0);
    checks++;
    if (stall_cnt !== 3'd0) begin failures++; $display("FAIL stats_clr got=%0d exp=0", stall_cnt); end
    adv();
    for (int k = 0; k < 8; k++) begin set_in(1'b0, 1'b0, 1'b0, '0, 1'b0); adv(); end
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checks++;
    if (stall_cnt !== 3'd7) begin failures++; $display("FAIL stats_sat got=%0d exp=7", stall_cnt); end
    adv();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      set_in(($urandom % 10) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0, DW'($urandom),
             ($urandom % 3) != 0, ($urandom % 40) == 0);
      checks += 3;
      if (in_ready !== exp_ir)  begin failures++; $display("FAIL rnd_in_ready n=%0d got=%b exp=%b", n, in_ready, exp_ir); end
      if (out_valid !== exp_ov) begin failures++; $display("FAIL rnd_out_valid n=%0d got=%b exp=%b", n, out_valid, exp_ov); end
      if (out_data !== exp_od)  begin failures++; $display("FAIL rnd_out_data n=%0d got=%h exp=%h", n, out_data, exp_od); end
`ifdef PIPE_STAGE_STATS_EN
      checks += 2;
      if (stall_cnt !== exp_stall[SW-1:0]) begin failures++; $display("FAIL rnd_stall n=%0d got=%0d exp=%0d", n, stall_cnt, exp_stall); end
      if (bubble_cnt !== exp_bub[SW-1:0])  begin failures++; $display("FAIL rnd_bubble n=%0d got=%0d exp=%0d", n, bubble_cnt, exp_bub); end
`endif
      adv();
      if (($urandom % 250) == 0) begin
        #2;
        do_reset();
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_halt();
    test_reset_mid();
`ifdef PIPE_STAGE_STATS_EN
    test_stats();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
